debounce_edge_detect: RTL



---
 rtl/debounce_edge_detect_pkg.sv | 26 ++
 rtl/debounce_edge_detect_sat.sv | 36 +++
 rtl/debounce_edge_detect.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/debounce_edge_detect_pkg.sv
// Shared types and helpers for the debounce / edge-detect block.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package debounce_edge_detect_pkg;

    // State encodings, also used by the bench to check the FSM state.
    localparam logic [1:0] ST_LOW      = 2'd0;
    localparam logic [1:0] ST_RISE_CHK = 2'd1;
    localparam logic [1:0] ST_HIGH     = 2'd2;
    localparam logic [1:0] ST_FALL_CHK = 2'd3;

    typedef enum logic [1:0] {
        LOW      = ST_LOW,
        RISE_CHK = ST_RISE_CHK,
        HIGH     = ST_HIGH,
        FALL_CHK = ST_FALL_CHK
    } state_e;

    // Counter width large enough to hold max(debounce, hold).
    function automatic int cnt_width(input int debounce, input int hold);
        int m;
        m = (debounce > hold) ? debounce : hold;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/debounce_edge_detect_sat.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Latency: count updates on the clk edge after clr/inc.
// Backpressure: none; inc is ignored once the count sits at MAX.
module sat_counter
    import debounce_edge_detect_pkg::*;
#(
    parameter int W   = 3,
    parameter int MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         at_max
);

    localparam logic [W-1:0] MAX_W = W'(MAX);

    logic [W-1:0] count_q;

    // Count register: clear has priority, increment stops at the ceiling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != MAX_W)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count  = count_q;
    assign at_max = (count_q == MAX_W);

endmodule

// File: rtl/debounce_edge_detect.sv
// Debounces a synchronized input; emits clean level, rise/fall pulses, one-shot long-press.
// Latency: level/rise follow DEBOUNCE agreeing samples; all outputs registered.
// Backpressure: none; sample_en low freezes state and counters and suppresses pulses.
module debounce_edge_detect
    import debounce_edge_detect_pkg::*;
#(
    parameter  int DEBOUNCE = 4,
    parameter  int HOLD     = 8,
    localparam int CW       = cnt_width(DEBOUNCE, HOLD)
) (
    input  logic clk,
    input  logic rst,
    input  logic in_sync,
    input  logic sample_en,
    output logic level,
    output logic rise,
    output logic fall,
    output logic long_press,
    output logic busy
);

    // hcnt value on the edge before it reaches HOLD; unused when HOLD is 0.
    localparam logic [CW-1:0] HOLD_M1 = (HOLD > 0) ? CW'(HOLD - 1) : '0;

    state_e state_q, state_d;
    logic   level_q, level_d;
    logic   rise_q, rise_d;
    logic   fall_q, fall_d;
    logic   busy_q, busy_d;
    logic   long_press_q, long_press_d;

    logic          cnt_clr, cnt_inc, cnt_done;
    logic [CW-1:0] cnt_unused;
    logic          hcnt_clr, hcnt_inc, hold_done;
    logic [CW-1:0] hcnt;

    // Agreeing-sample counter; its ceiling (DEBOUNCE-1) is the accept condition,
    // and the raw count is only of interest when debugging.
    sat_counter #(.W(CW), .MAX(DEBOUNCE - 1)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .count  (cnt_unused),
        .at_max (cnt_done)
    );

    // Hold counter; it sits at HOLD exactly when the long press has fired,
    // so its ceiling flag doubles as hold_done. HOLD=0 leaves it permanently
    // "done", which disables long_press.
    sat_counter #(.W(CW), .MAX(HOLD)) u_hcnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (hcnt_clr),
        .inc    (hcnt_inc),
        .count  (hcnt),
        .at_max (hold_done)
    );

    // Next-state decode; only acts on sample strobes.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        if (sample_en) begin
            case (state_q)
                LOW: begin
                    if (in_sync) begin
                        state_d = RISE_CHK;
                        cnt_inc = 1'b1;
                    end else begin
                        cnt_clr = 1'b1;
                    end
                end
                RISE_CHK: begin
                    if (!in_sync) begin
                        state_d = LOW;
                        cnt_clr = 1'b1;
                    end else if (cnt_done) begin
                        state_d = HIGH;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                HIGH: begin
                    if (!in_sync) begin
                        state_d = FALL_CHK;
                        cnt_inc = 1'b1;
                    end else begin
                        cnt_clr = 1'b1;
                    end
                end
                FALL_CHK: begin
                    if (in_sync) begin
                        state_d = HIGH;
                        cnt_clr = 1'b1;
                    end else if (cnt_done) begin
                        state_d = LOW;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: begin
                    state_d = LOW;
                    level_d = 1'b0;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    // The accept edge of a rise counts as hold sample 1, and the accept edge
    // of a fall still counts as a level=1 sample, so long_press can land with fall.
    assign hcnt_inc     = sample_en & (level_q | level_d);
    assign hcnt_clr     = ~level_q & ~level_d;
    assign long_press_d = hcnt_inc & ~hold_done & (hcnt == HOLD_M1);
    assign busy_d       = (state_d == RISE_CHK) || (state_d == FALL_CHK);

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LOW;
            level_q      <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            busy_q       <= 1'b0;
            long_press_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            busy_q       <= busy_d;
            long_press_q <= long_press_d;
        end
    end

    assign level      = level_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign long_press = long_press_q;
    assign busy       = busy_q;

endmodule
